// File: rtl/game_pkg.sv
// Shared types, colour constants and pixel helpers for the frame compositor.
package game_pkg;

  typedef enum logic [2:0] {LOST = 3'd0, PLAYING = 3'd1, WON = 3'd2} game_state_t;
  typedef enum logic [1:0] {PLAY = 2'd0, LOSE = 2'd1, WIN = 2'd2} banner_state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam rgb_t COLOR_GOAL  = 24'hFFD700;
  localparam rgb_t COLOR_HIT   = 24'hFF0000;
  localparam rgb_t COLOR_FLASH = 24'hFFFFFF;
  localparam rgb_t COLOR_BLACK = 24'h000000;

  // Stage-1 register: per-pixel data plus a snapshot of frame-level state
  typedef struct packed {
    logic          wall;
    logic          person;
    logic          coll;
    banner_state_t bst;
    logic          flash_on;
    logic          blink_on;
    logic          parity;
    rgb_t          cam;
    rgb_t          wall_c;
    logic [10:0]   h;
    logic [9:0]    v;
  } s1_t;

  function automatic rgb_t expand565(input logic [15:0] c);
    rgb_t o;
    o.r = {c[15:11], c[15:13]};
    o.g = {c[10:5],  c[10:9]};
    o.b = {c[4:0],   c[4:2]};
    return o;
  endfunction

  function automatic rgb_t half(input rgb_t c);
    rgb_t o;
    o.r = {1'b0, c.r[7:1]};
    o.g = {1'b0, c.g[7:1]};
    o.b = {1'b0, c.b[7:1]};
    return o;
  endfunction

  // Halving both operands first keeps every channel sum within 8 bits
  function automatic rgb_t blend(input rgb_t a, input rgb_t b);
    rgb_t ha, hb, o;
    ha = half(a);
    hb = half(b);
    o.r = ha.r + hb.r;
    o.g = ha.g + hb.g;
    o.b = ha.b + hb.b;
    return o;
  endfunction

endpackage

// File: rtl/frame_countdown.sv
// Per-frame down counter: load wins over decrement, saturates at zero.
module frame_countdown #(
  parameter int W        = 8,
  parameter int LOAD_VAL = 8
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic load,
  input  logic dec,
  output logic nonzero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)                  cnt <= '0;
    else if (load)               cnt <= W'(LOAD_VAL);
    else if (dec && cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign nonzero = (cnt != '0);

endmodule

// File: rtl/game_frame_compositor.sv
// Final pixel compositor: wall/player/collision blend with per-frame flash
// timer and win/lose banner, fixed 2-cycle pixel pipeline.
module game_frame_compositor
  import game_pkg::*;
#(
  parameter int SCREEN_WIDTH     = 1280,
  parameter int SCREEN_HEIGHT    = 720,
  parameter int MAX_WALL_DEPTH   = 75,
  parameter int GOAL_DEPTH       = 60,
  parameter int GOAL_DEPTH_DELTA = 10,
  parameter int FLASH_FRAMES     = 8,
  parameter int BANNER_FRAMES    = 120
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        data_valid_in,
  input  logic [15:0] camera_pixel_in,
  input  logic [7:0]  wall_depth_in,
  input  logic        is_wall_in,
  input  logic        is_person_in,
  input  logic        is_collision_in,
  input  logic [2:0]  game_state_in,
  output logic [10:0] hcount_out,
  output logic [9:0]  vcount_out,
  output logic        data_valid_out,
  output logic [23:0] pixel_out,
  output logic        banner_active_out
);

  localparam int STAGES = 2;
  localparam int FW = $clog2(FLASH_FRAMES + 1);
  localparam int BW = $clog2(BANNER_FRAMES + 1);

  logic          frame_end, hit_now, hit_seen, parity;
  logic          flash_on, blink_on, banner_load;
  banner_state_t state, state_nxt;
  logic [STAGES:1] vld_pipe;
  s1_t           s1;
  rgb_t          cam_c, wall_c, pix;
  logic [7:0]    depth_c, grey;
  logic [9:0]    ramp;
  logic          in_goal;

  assign frame_end = data_valid_in && hcount_in == 11'(SCREEN_WIDTH - 1)
                                   && vcount_in == 10'(SCREEN_HEIGHT - 1);
  assign hit_now   = data_valid_in && is_collision_in;

  // Frame-level state
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      hit_seen <= 1'b0;
      parity   <= 1'b0;
      state    <= PLAY;
    end else begin
      state <= state_nxt;
      if (frame_end) begin
        hit_seen <= 1'b0;
        parity   <= ~parity;
      end else if (hit_now) begin
        hit_seen <= 1'b1;
      end
    end
  end

  // Undefined game states fall through to the "playing" branch
  always_comb begin
    state_nxt   = state;
    banner_load = 1'b0;
    if (frame_end) begin
      unique case (state)
        PLAY: begin
          if (game_state_in == LOST)     begin state_nxt = LOSE; banner_load = 1'b1; end
          else if (game_state_in == WON) begin state_nxt = WIN;  banner_load = 1'b1; end
        end
        LOSE: begin
          if (game_state_in == WON)       begin state_nxt = WIN; banner_load = 1'b1; end
          else if (game_state_in != LOST) state_nxt = PLAY;
        end
        WIN: begin
          if (game_state_in == LOST)     begin state_nxt = LOSE; banner_load = 1'b1; end
          else if (game_state_in != WON) state_nxt = PLAY;
        end
        default: state_nxt = PLAY;
      endcase
    end
  end

  assign banner_active_out = (state != PLAY);

  frame_countdown #(.W(FW), .LOAD_VAL(FLASH_FRAMES)) u_flash (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .load    (frame_end && (hit_seen || hit_now)),
    .dec     (frame_end),
    .nonzero (flash_on)
  );

  frame_countdown #(.W(BW), .LOAD_VAL(BANNER_FRAMES)) u_banner (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .load    (banner_load),
    .dec     (frame_end),
    .nonzero (blink_on)
  );

  // Stage 1: colour prep
  always_comb begin
    cam_c   = expand565(camera_pixel_in);
    depth_c = (wall_depth_in > 8'(MAX_WALL_DEPTH)) ? 8'(MAX_WALL_DEPTH) : wall_depth_in;
    ramp    = 10'(depth_c) * 10'd3;
    grey    = (ramp > 10'd255) ? 8'hFF : ramp[7:0];
    in_goal = (int'(wall_depth_in) >= GOAL_DEPTH - GOAL_DEPTH_DELTA) &&
              (int'(wall_depth_in) <= GOAL_DEPTH + GOAL_DEPTH_DELTA);
    wall_c  = in_goal ? COLOR_GOAL : {grey, grey, grey};
  end

  // Frame state is snapshotted with the pixel so the frame-end pixel keeps the old state
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      s1       <= '0;
      vld_pipe <= '0;
    end else begin
      vld_pipe    <= {vld_pipe[STAGES-1:1], data_valid_in};
      s1.wall     <= is_wall_in;
      s1.person   <= is_person_in;
      s1.coll     <= is_collision_in;
      s1.bst      <= state;
      s1.flash_on <= flash_on;
      s1.blink_on <= blink_on;
      s1.parity   <= parity;
      s1.cam      <= cam_c;
      s1.wall_c   <= wall_c;
      s1.h        <= hcount_in;
      s1.v        <= vcount_in;
    end
  end

  // Stage 2: select
  always_comb begin
    pix = COLOR_BLACK;
    if (vld_pipe[1]) begin
      if (s1.bst != PLAY) begin
        if (!(s1.blink_on && s1.parity)) begin
          if (s1.bst == LOSE) pix.r = s1.cam.r;
          else                pix.g = s1.cam.g;
        end
      end else if (s1.coll) begin
        pix = (s1.flash_on && s1.parity) ? COLOR_FLASH : COLOR_HIT;
      end else if (s1.wall) begin
        pix = blend(s1.wall_c, s1.cam);
      end else if (s1.person) begin
        pix = s1.cam;
      end else begin
        pix = half(s1.cam);
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pixel_out  <= '0;
      hcount_out <= '0;
      vcount_out <= '0;
    end else begin
      pixel_out  <= pix;
      hcount_out <= s1.h;
      vcount_out <= s1.v;
    end
  end

  assign data_valid_out = vld_pipe[STAGES];

endmodule

// File: tb/tb_game_frame_compositor.sv
// Directed bench for game_frame_compositor on a shrunken 8x4 frame.
module tb_game_frame_compositor;

  localparam int W = 8;
  localparam int H = 4;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic [10:0] hcount_in = '0;
  logic [9:0]  vcount_in = '0;
  logic        data_valid_in = 1'b0;
  logic [15:0] camera_pixel_in = '0;
  logic [7:0]  wall_depth_in = '0;
  logic        is_wall_in = 1'b0;
  logic        is_person_in = 1'b0;
  logic        is_collision_in = 1'b0;
  logic [2:0]  game_state_in = 3'd1;
  logic [10:0] hcount_out;
  logic [9:0]  vcount_out;
  logic        data_valid_out;
  logic [23:0] pixel_out;
  logic        banner_active_out;

  int total = 0;
  int bad   = 0;
  bit par   = 1'b0;

  game_frame_compositor #(.SCREEN_WIDTH(W), .SCREEN_HEIGHT(H)) dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .hcount_in         (hcount_in),
    .vcount_in         (vcount_in),
    .data_valid_in     (data_valid_in),
    .camera_pixel_in   (camera_pixel_in),
    .wall_depth_in     (wall_depth_in),
    .is_wall_in        (is_wall_in),
    .is_person_in      (is_person_in),
    .is_collision_in   (is_collision_in),
    .game_state_in     (game_state_in),
    .hcount_out        (hcount_out),
    .vcount_out        (vcount_out),
    .data_valid_out    (data_valid_out),
    .pixel_out         (pixel_out),
    .banner_active_out (banner_active_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Present one pixel for one clock, then idle the valid/flag inputs
  task automatic drive(input logic [10:0] h, input logic [9:0] v, input logic dv,
                       input logic [15:0] cam, input logic [7:0] d,
                       input logic w, input logic p, input logic c, input logic [2:0] gs);
    hcount_in = h; vcount_in = v; data_valid_in = dv; camera_pixel_in = cam;
    wall_depth_in = d; is_wall_in = w; is_person_in = p; is_collision_in = c;
    game_state_in = gs;
    @(posedge clk_in); #1;
    if (dv && h == 11'(W-1) && v == 10'(H-1)) par = ~par;
    data_valid_in = 1'b0; is_wall_in = 1'b0; is_person_in = 1'b0; is_collision_in = 1'b0;
  endtask

  task automatic pxc(input string tag, input logic [23:0] exp);
    @(posedge clk_in); #1;
    chk(tag, {8'h0, pixel_out}, {8'h0, exp});
  endtask

  task automatic frm(input logic [2:0] gs);
    drive(11'(W-1), 10'(H-1), 1'b1, 16'h0000, 8'd0, 1'b0, 1'b0, 1'b0, gs);
  endtask

  function automatic logic [23:0] hit_exp(input bit active);
    return (active && par) ? 24'hFFFFFF : 24'hFF0000;
  endfunction

  function automatic logic [23:0] ban_exp(input bit lose, input bit blink);
    if (blink && par) return 24'h000000;
    return lose ? 24'h840000 : 24'h008200;
  endfunction

  initial begin
    #12;
    chk("rst_pix", {8'h0, pixel_out}, 32'h0);
    chk("rst_dv", {31'h0, data_valid_out}, 32'h0);
    chk("rst_ban", {31'h0, banner_active_out}, 32'h0);
    repeat (2) @(posedge clk_in);
    #1 rst_in = 1'b0;

    // Basic colour path
    drive(11'd3, 10'd1, 1'b1, 16'hFFFF, 8'd30, 1'b1, 1'b0, 1'b0, 3'd1);
    chk("lat1_dv", {31'h0, data_valid_out}, 32'h0);
    pxc("wall_d30", 24'hACACAC);
    chk("lat2_dv", {31'h0, data_valid_out}, 32'h1);
    chk("h_out", {21'h0, hcount_out}, 32'd3);
    chk("v_out", {22'h0, vcount_out}, 32'd1);
    drive(11'd0, 10'd0, 1'b1, 16'h0000, 8'd55, 1'b1, 1'b0, 1'b0, 3'd1); pxc("goal_d55", 24'h7F6B00);
    drive(11'd0, 10'd0, 1'b1, 16'h0000, 8'd50, 1'b1, 1'b0, 1'b0, 3'd1); pxc("goal_d50", 24'h7F6B00);
    drive(11'd0, 10'd0, 1'b1, 16'h0000, 8'd70, 1'b1, 1'b0, 1'b0, 3'd1); pxc("goal_d70", 24'h7F6B00);
    drive(11'd0, 10'd0, 1'b1, 16'h0000, 8'd49, 1'b1, 1'b0, 1'b0, 3'd1); pxc("ramp_d49", 24'h494949);
    drive(11'd0, 10'd0, 1'b1, 16'h0000, 8'd71, 1'b1, 1'b0, 1'b0, 3'd1); pxc("ramp_d71", 24'h6A6A6A);
    drive(11'd0, 10'd0, 1'b1, 16'h8410, 8'd30, 1'b1, 1'b1, 1'b0, 3'd1); pxc("wall_cam", 24'h6F6E6F);
    drive(11'd0, 10'd0, 1'b1, 16'h8410, 8'd30, 1'b0, 1'b1, 1'b0, 3'd1); pxc("person", 24'h848284);
    drive(11'd0, 10'd0, 1'b1, 16'h8410, 8'd30, 1'b0, 1'b0, 1'b0, 3'd1); pxc("bg", 24'h424142);
    drive(11'd0, 10'd0, 1'b0, 16'hFFFF, 8'd30, 1'b1, 1'b1, 1'b1, 3'd1); pxc("invalid", 24'h000000);

    // Collision flash
    if (!par) frm(3'd1);
    drive(11'd2, 10'd1, 1'b1, 16'h0, 8'd0, 1'b0, 1'b0, 1'b1, 3'd1); pxc("f0_red", 24'hFF0000);
    frm(3'd1);
    drive(11'd2, 10'd1, 1'b1, 16'h0, 8'd0, 1'b0, 1'b0, 1'b1, 3'd1); pxc("f1", hit_exp(1'b1));
    frm(3'd1);
    drive(11'd2, 10'd1, 1'b1, 16'h0, 8'd0, 1'b0, 1'b0, 1'b1, 3'd1); pxc("f2_white", hit_exp(1'b1));
    frm(3'd1);
    repeat (7) frm(3'd1);
    drive(11'd2, 10'd1, 1'b1, 16'h0, 8'd0, 1'b0, 1'b0, 1'b1, 3'd1); pxc("f_8th", hit_exp(1'b1));
    frm(3'd1);
    drive(11'd2, 10'd1, 1'b1, 16'h0, 8'd0, 1'b0, 1'b0, 1'b1, 3'd1); pxc("f_reload", hit_exp(1'b1));
    frm(3'd1);
    repeat (8) frm(3'd1);
    drive(11'(W-1), 10'(H-1), 1'b1, 16'h0, 8'd0, 1'b0, 1'b0, 1'b1, 3'd1); pxc("f_9th_red", 24'hFF0000);
    frm(3'd1);
    drive(11'd2, 10'd1, 1'b1, 16'h0, 8'd0, 1'b0, 1'b0, 1'b1, 3'd1); pxc("fe_counted", hit_exp(1'b1));
    frm(3'd1);

    // Lose banner
    if (!par) frm(3'd1);
    drive(11'd1, 10'd0, 1'b1, 16'h8410, 8'd0, 1'b0, 1'b0, 1'b0, 3'd0); pxc("gs_mid", 24'h424142);
    chk("ban_mid", {31'h0, banner_active_out}, 32'h0);
    drive(11'(W-1), 10'(H-1), 1'b1, 16'h8410, 8'd0, 1'b0, 1'b1, 1'b0, 3'd0);
    chk("ban_on", {31'h0, banner_active_out}, 32'h1);
    pxc("fe_old", 24'h848284);
    drive(11'd0, 10'd0, 1'b1, 16'h8410, 8'd0, 1'b0, 1'b0, 1'b0, 3'd0); pxc("b1", ban_exp(1'b1, 1'b1));
    frm(3'd0);
    drive(11'd0, 10'd0, 1'b1, 16'h8410, 8'd0, 1'b0, 1'b0, 1'b0, 3'd0); pxc("b2", ban_exp(1'b1, 1'b1));
    frm(3'd0);
    repeat (117) frm(3'd0);
    drive(11'd0, 10'd0, 1'b1, 16'h8410, 8'd0, 1'b0, 1'b0, 1'b0, 3'd0); pxc("b120", ban_exp(1'b1, 1'b1));
    frm(3'd0);
    drive(11'd0, 10'd0, 1'b1, 16'h8410, 8'd0, 1'b0, 1'b0, 1'b0, 3'd0); pxc("b121", ban_exp(1'b1, 1'b0));
    frm(3'd0);
    drive(11'd0, 10'd0, 1'b1, 16'h8410, 8'd0, 1'b0, 1'b0, 1'b0, 3'd0); pxc("b122", ban_exp(1'b1, 1'b0));
    frm(3'd2);

    // Direct switch to win, then back to play via an undefined state code
    drive(11'd0, 10'd0, 1'b1, 16'h8410, 8'd0, 1'b0, 1'b0, 1'b0, 3'd2); pxc("w1", ban_exp(1'b0, 1'b1));
    frm(3'd2);
    drive(11'd0, 10'd0, 1'b1, 16'h8410, 8'd0, 1'b0, 1'b0, 1'b0, 3'd5); pxc("w2", ban_exp(1'b0, 1'b1));
    chk("ban_w_mid", {31'h0, banner_active_out}, 32'h1);
    frm(3'd5);
    chk("ban_off", {31'h0, banner_active_out}, 32'h0);
    drive(11'd0, 10'd0, 1'b1, 16'h8410, 8'd0, 1'b0, 1'b0, 1'b0, 3'd1); pxc("play_back", 24'h424142);

    // Reset mid-frame while in LOSE
    frm(3'd0);
    chk("ban_lose2", {31'h0, banner_active_out}, 32'h1);
    drive(11'd1, 10'd2, 1'b1, 16'h8410, 8'd0, 1'b0, 1'b0, 1'b0, 3'd0);
    @(posedge clk_in); #1;
    chk("pre_rst_dv", {31'h0, data_valid_out}, 32'h1);
    #2 rst_in = 1'b1;
    #1;
    chk("mrst_pix", {8'h0, pixel_out}, 32'h0);
    chk("mrst_dv", {31'h0, data_valid_out}, 32'h0);
    chk("mrst_v", {22'h0, vcount_out}, 32'h0);
    chk("mrst_ban", {31'h0, banner_active_out}, 32'h0);
    @(posedge clk_in); #1 rst_in = 1'b0;
    drive(11'd2, 10'd2, 1'b1, 16'h8410, 8'd0, 1'b0, 1'b0, 1'b0, 3'd0);
    chk("post_lat1", {31'h0, data_valid_out}, 32'h0);
    pxc("post_play", 24'h424142);
    chk("post_dv", {31'h0, data_valid_out}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
